// File: rtl/cgra_mem_pkg.sv
// Shared loader definitions: header beat layout, target decoding and loader FSM states.
// The header is {count-1, base address, target} with the target in the low byte.
package cgra_mem_pkg;

  localparam int HDR_TGT_W  = 8;
  localparam int HDR_BASE_W = 16;
  localparam int HDR_CNT_W  = 16;
  localparam int HDR_WIDTH  = HDR_TGT_W + HDR_BASE_W + HDR_CNT_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } loadState_t;

  typedef struct packed {
    logic [HDR_CNT_W-1:0]  countM1;
    logic [HDR_BASE_W-1:0] base;
    logic [HDR_TGT_W-1:0]  target;
  } loadHeader_t;

  function automatic logic isValidTarget(input logic [HDR_TGT_W-1:0] target,
                                         input int numTargets);
    return int'(target) < numTargets;
  endfunction

endpackage

// File: rtl/RAM_SDP.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// A read of the address being written in the same cycle returns the old word.
module RAM_SDP #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iWriteEnable,
  input  logic [ADDR_WIDTH-1:0] iWriteAddress,
  input  logic [DATA_WIDTH-1:0] iWriteData,
  input  logic                  iReadEnable,
  input  logic [ADDR_WIDTH-1:0] iReadAddress,
  output logic [DATA_WIDTH-1:0] oReadData
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the output register is reset.
  always_ff @(posedge iClk) begin
    if (iWriteEnable) mem[iWriteAddress] <= iWriteData;
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset)           oReadData <= '0;
    else if (iReadEnable) oReadData <= mem[iReadAddress];
  end

endmodule

// File: rtl/RAM_SDP_BE.sv
// Simple dual-port RAM with per-byte write enables and a registered, enabled read port.
// A read of the address being written in the same cycle returns the old word.
module RAM_SDP_BE #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    iClk,
  input  logic                    iReset,
  input  logic [DATA_WIDTH/8-1:0] iWriteEnable,
  input  logic [ADDR_WIDTH-1:0]   iWriteAddress,
  input  logic [DATA_WIDTH-1:0]   iWriteData,
  input  logic                    iReadEnable,
  input  logic [ADDR_WIDTH-1:0]   iReadAddress,
  output logic [DATA_WIDTH-1:0]   oReadData
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge iClk) begin
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (iWriteEnable[b]) mem[iWriteAddress][b*8 +: 8] <= iWriteData[b*8 +: 8];
    end
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset)           oReadData <= '0;
    else if (iReadEnable) oReadData <= mem[iReadAddress];
  end

endmodule

// File: rtl/cgra_mem_load_fsm.sv
// Burst loader control: decodes header beats, walks address/remaining counters and
// flags bursts to unknown targets, which are drained without writing.
module cgra_mem_load_fsm
  import cgra_mem_pkg::*;
#(
  parameter int NUM_TARGETS = 7
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iRun,
  input  logic                  iLoad_Valid,
  input  logic [HDR_WIDTH-1:0]  iHeader,
  output logic                  oLoad_Ready,
  output logic                  oLoad_Busy,
  output logic                  oLoad_Done,
  output logic                  oLoad_Error,
  output logic                  oWrite,
  output logic [HDR_TGT_W-1:0]  oTarget,
  output logic [HDR_BASE_W-1:0] oAddress
);

  loadState_t            state, stateNext;
  logic [HDR_BASE_W-1:0] addr, addrNext;
  logic [HDR_CNT_W-1:0]  rem, remNext;
  logic [HDR_TGT_W-1:0]  target, targetNext;
  logic                  done, doneNext;
  logic                  error, errorNext;
  logic                  accept;
  loadHeader_t           header;

  assign header      = loadHeader_t'(iHeader);
  assign oLoad_Ready = !iReset && !iRun;
  assign accept      = iLoad_Valid && oLoad_Ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state  <= IDLE;
      addr   <= '0;
      rem    <= '0;
      target <= '0;
      done   <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= stateNext;
      addr   <= addrNext;
      rem    <= remNext;
      target <= targetNext;
      done   <= doneNext;
      error  <= errorNext;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    stateNext  = state;
    addrNext   = addr;
    remNext    = rem;
    targetNext = target;
    doneNext   = 1'b0;
    errorNext  = error;
    oWrite     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          targetNext = header.target;
          addrNext   = header.base;
          remNext    = header.countM1;
          if (isValidTarget(header.target, NUM_TARGETS)) begin
            stateNext = LOAD;
          end else begin
            stateNext = DRAIN;
            errorNext = 1'b1;
          end
        end
      end
      LOAD, DRAIN: begin
        if (accept) begin
          oWrite   = (state == LOAD);
          addrNext = addr + 16'd1;
          remNext  = rem - 16'd1;
          if (rem == '0) begin
            stateNext = IDLE;
            doneNext  = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign oLoad_Busy  = (state != IDLE);
  assign oLoad_Done  = done;
  assign oLoad_Error = error;
  assign oTarget     = target;
  assign oAddress    = addr;

endmodule

// File: rtl/cgra_memory_loader_bank.sv
// CGRA memory bank: ID/IMM instruction memories and byte-enabled local data memories,
// programmable through a valid/ready burst loader while the array is halted.
module cgra_memory_loader_bank
  import cgra_mem_pkg::*;
#(
  parameter int D_WIDTH           = 32,
  parameter int I_WIDTH           = 12,
  parameter int I_IMM_WIDTH       = 33,
  parameter int IM_MEM_ADDR_WIDTH = 8,
  parameter int LM_MEM_ADDR_WIDTH = 8,
  parameter int NUM_ID            = 5,
  parameter int NUM_IMM           = 1,
  parameter int NUM_LOCAL_DMEM    = 1,
  parameter int LOAD_WIDTH        = 40
) (
  input  logic                                          iClk,
  input  logic                                          iReset,
  input  logic                                          iRun,
  input  logic [NUM_LOCAL_DMEM*D_WIDTH/8-1:0]           iLM_WriteEnable,
  input  logic [NUM_LOCAL_DMEM-1:0]                     iLM_ReadEnable,
  input  logic [NUM_LOCAL_DMEM*LM_MEM_ADDR_WIDTH-1:0]   iLM_WriteAddress,
  input  logic [NUM_LOCAL_DMEM*D_WIDTH-1:0]             iLM_WriteData,
  input  logic [NUM_LOCAL_DMEM*LM_MEM_ADDR_WIDTH-1:0]   iLM_ReadAddress,
  output logic [NUM_LOCAL_DMEM*D_WIDTH-1:0]             oLM_ReadData,
  input  logic [NUM_ID+NUM_IMM-1:0]                     iIM_ReadEnable,
  input  logic [(NUM_ID+NUM_IMM)*IM_MEM_ADDR_WIDTH-1:0] iIM_ReadAddress,
  output logic [NUM_ID*I_WIDTH+NUM_IMM*I_IMM_WIDTH-1:0] oIM_ReadData,
  input  logic                                          iLoad_Valid,
  output logic                                          oLoad_Ready,
  input  logic [LOAD_WIDTH-1:0]                         iLoad_Data,
  output logic                                          oLoad_Busy,
  output logic                                          oLoad_Done,
  output logic                                          oLoad_Error
);

  localparam int NUM_IM   = NUM_ID + NUM_IMM;
  localparam int BE_WIDTH = D_WIDTH / 8;

  logic                  loadWrite;
  logic [HDR_TGT_W-1:0]  loadTarget;
  logic [HDR_BASE_W-1:0] loadAddress;
  logic                  unusedLoadBits;

  cgra_mem_load_fsm #(
    .NUM_TARGETS(NUM_IM + NUM_LOCAL_DMEM)
  ) u_fsm (
    .iClk       (iClk),
    .iReset     (iReset),
    .iRun       (iRun),
    .iLoad_Valid(iLoad_Valid),
    .iHeader    (iLoad_Data[HDR_WIDTH-1:0]),
    .oLoad_Ready(oLoad_Ready),
    .oLoad_Busy (oLoad_Busy),
    .oLoad_Done (oLoad_Done),
    .oLoad_Error(oLoad_Error),
    .oWrite     (loadWrite),
    .oTarget    (loadTarget),
    .oAddress   (loadAddress)
  );

  // Address bits above each memory's width are dropped, which gives the modulo wrap.
  assign unusedLoadBits = ^{iLoad_Data, loadAddress};

  for (genvar i = 0; i < NUM_IM; i++) begin : g_im
    localparam int W   = (i < NUM_ID) ? I_WIDTH : I_IMM_WIDTH;
    localparam int OFF = (i < NUM_ID) ? i*I_WIDTH : NUM_ID*I_WIDTH + (i-NUM_ID)*I_IMM_WIDTH;
    localparam logic [HDR_TGT_W-1:0] TGT = HDR_TGT_W'(i);

    logic wren;
    assign wren = loadWrite && (loadTarget == TGT);

    RAM_SDP #(
      .DATA_WIDTH(W),
      .ADDR_WIDTH(IM_MEM_ADDR_WIDTH)
    ) u_im (
      .iClk         (iClk),
      .iReset       (iReset),
      .iWriteEnable (wren),
      .iWriteAddress(loadAddress[IM_MEM_ADDR_WIDTH-1:0]),
      .iWriteData   (iLoad_Data[W-1:0]),
      .iReadEnable  (iIM_ReadEnable[i]),
      .iReadAddress (iIM_ReadAddress[i*IM_MEM_ADDR_WIDTH +: IM_MEM_ADDR_WIDTH]),
      .oReadData    (oIM_ReadData[OFF +: W])
    );
  end

  for (genvar j = 0; j < NUM_LOCAL_DMEM; j++) begin : g_lm
    localparam logic [HDR_TGT_W-1:0] TGT = HDR_TGT_W'(NUM_IM + j);

    logic                         loaderHit;
    logic [BE_WIDTH-1:0]          wren;
    logic [LM_MEM_ADDR_WIDTH-1:0] waddr;
    logic [D_WIDTH-1:0]           wdata;

    // The loader owns the whole write port for the cycle, whatever address the array used.
    assign loaderHit = loadWrite && (loadTarget == TGT);
    assign wren  = loaderHit ? {BE_WIDTH{1'b1}} : iLM_WriteEnable[j*BE_WIDTH +: BE_WIDTH];
    assign waddr = loaderHit ? loadAddress[LM_MEM_ADDR_WIDTH-1:0]
                             : iLM_WriteAddress[j*LM_MEM_ADDR_WIDTH +: LM_MEM_ADDR_WIDTH];
    assign wdata = loaderHit ? iLoad_Data[D_WIDTH-1:0] : iLM_WriteData[j*D_WIDTH +: D_WIDTH];

    RAM_SDP_BE #(
      .DATA_WIDTH(D_WIDTH),
      .ADDR_WIDTH(LM_MEM_ADDR_WIDTH)
    ) u_lm (
      .iClk         (iClk),
      .iReset       (iReset),
      .iWriteEnable (wren),
      .iWriteAddress(waddr),
      .iWriteData   (wdata),
      .iReadEnable  (iLM_ReadEnable[j]),
      .iReadAddress (iLM_ReadAddress[j*LM_MEM_ADDR_WIDTH +: LM_MEM_ADDR_WIDTH]),
      .oReadData    (oLM_ReadData[j*D_WIDTH +: D_WIDTH])
    );
  end

endmodule

// File: tb/tb_cgra_memory_loader_bank.sv
// Directed-random bench for the memory loader bank: bursts are mirrored into plain
// per-memory arrays and read back through the fetch and LSU ports.
module tb_cgra_memory_loader_bank;

  localparam int NI    = 5;
  localparam int ID_W  = 12;
  localparam int IMM_W = 33;
  localparam int D_W   = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          iClk = 1'b0;
  logic          iReset;
  logic          iRun;
  logic [3:0]    iLM_WriteEnable;
  logic [0:0]    iLM_ReadEnable;
  logic [7:0]    iLM_WriteAddress;
  logic [31:0]   iLM_WriteData;
  logic [7:0]    iLM_ReadAddress;
  logic [31:0]   oLM_ReadData;
  logic [5:0]    iIM_ReadEnable;
  logic [47:0]   iIM_ReadAddress;
  logic [92:0]   oIM_ReadData;
  logic          iLoad_Valid;
  logic          oLoad_Ready;
  logic [39:0]   iLoad_Data;
  logic          oLoad_Busy;
  logic          oLoad_Done;
  logic          oLoad_Error;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;

  logic [ID_W-1:0]  idModel  [NI][DEPTH];
  logic [IMM_W-1:0] immModel [DEPTH];
  logic [D_W-1:0]   lmModel  [DEPTH];

  cgra_memory_loader_bank dut (
    .iClk            (iClk),
    .iReset          (iReset),
    .iRun            (iRun),
    .iLM_WriteEnable (iLM_WriteEnable),
    .iLM_ReadEnable  (iLM_ReadEnable),
    .iLM_WriteAddress(iLM_WriteAddress),
    .iLM_WriteData   (iLM_WriteData),
    .iLM_ReadAddress (iLM_ReadAddress),
    .oLM_ReadData    (oLM_ReadData),
    .iIM_ReadEnable  (iIM_ReadEnable),
    .iIM_ReadAddress (iIM_ReadAddress),
    .oIM_ReadData    (oIM_ReadData),
    .iLoad_Valid     (iLoad_Valid),
    .oLoad_Ready     (oLoad_Ready),
    .iLoad_Data      (iLoad_Data),
    .oLoad_Busy      (oLoad_Busy),
    .oLoad_Done      (oLoad_Done),
    .oLoad_Error     (oLoad_Error)
  );

  always #5 iClk = ~iClk;

  always @(negedge iClk) if (oLoad_Done === 1'b1) doneCount++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [39:0] hdr(input int tgt, input int base, input int cnt);
    return {16'(cnt - 1), 16'(base), 8'(tgt)};
  endfunction

  function automatic logic [39:0] rand40();
    return {8'($urandom), 32'($urandom)};
  endfunction

  // Expected effect of a burst: consecutive words from base, wrapping at the memory depth.
  task automatic modelBurst(input int tgt, input int base, input logic [39:0] vals[$]);
    foreach (vals[k]) begin
      int a;
      a = (base + k) % DEPTH;
      if (tgt < NI)       idModel[tgt][a] = vals[k][ID_W-1:0];
      else if (tgt == NI) immModel[a]     = vals[k][IMM_W-1:0];
      else                lmModel[a]      = vals[k][D_W-1:0];
    end
  endtask

  // Called and returns at a falling edge.
  task automatic sendBeat(input logic [39:0] d);
    int waitCycles;
    waitCycles = 0;
    iLoad_Valid = 1'b1;
    iLoad_Data  = d;
    do begin
      @(posedge iClk);
      waitCycles++;
    end while (!oLoad_Ready && waitCycles < 100);
    if (!oLoad_Ready) begin
      checks++;
      errors++;
      $display("FAIL beat_accept: observed no handshake in %0d cycles, expected acceptance", waitCycles);
    end
    @(negedge iClk);
    iLoad_Valid = 1'b0;
  endtask

  task automatic sendBurst(input int tgt, input int base, input logic [39:0] vals[$]);
    sendBeat(hdr(tgt, base, vals.size()));
    foreach (vals[k]) sendBeat(vals[k]);
  endtask

  task automatic readIm(input int idx, input int addr, output logic [63:0] q);
    iIM_ReadEnable = 6'(1 << idx);
    iIM_ReadAddress[idx*AW +: AW] = 8'(addr);
    @(posedge iClk);
    @(negedge iClk);
    iIM_ReadEnable = '0;
    if (idx < NI) q = 64'(oIM_ReadData[idx*ID_W +: ID_W]);
    else          q = 64'(oIM_ReadData[NI*ID_W +: IMM_W]);
  endtask

  task automatic readLm(input int addr, output logic [63:0] q);
    iLM_ReadEnable  = 1'b1;
    iLM_ReadAddress = 8'(addr);
    @(posedge iClk);
    @(negedge iClk);
    iLM_ReadEnable = 1'b0;
    q = 64'(oLM_ReadData);
  endtask

  task automatic arrayWrite(input logic [3:0] be, input int addr, input logic [31:0] data);
    iLM_WriteEnable  = be;
    iLM_WriteAddress = 8'(addr);
    iLM_WriteData    = data;
    @(posedge iClk);
    @(negedge iClk);
    iLM_WriteEnable = '0;
    for (int b = 0; b < 4; b++) if (be[b]) lmModel[addr][b*8 +: 8] = data[b*8 +: 8];
  endtask

  // One payload beat presented in the same cycle as a full-word array write.
  task automatic beatWithArrayWrite(input logic [39:0] d, input int addr, input logic [31:0] data);
    iLoad_Valid      = 1'b1;
    iLoad_Data       = d;
    iLM_WriteEnable  = 4'hF;
    iLM_WriteAddress = 8'(addr);
    iLM_WriteData    = data;
    @(posedge iClk);
    check("collide_ready", 64'(oLoad_Ready), 64'd1);
    @(negedge iClk);
    iLoad_Valid     = 1'b0;
    iLM_WriteEnable = '0;
  endtask

  initial begin
    logic [39:0]  beats[$];
    logic [63:0]  q, qHold;
    int           doneBefore;
    int           base;
    logic [31:0]  v1, v2, w6, x5, x6, y6;
    logic [39:0]  l5, l20;

    iReset = 1'b1; iRun = 1'b0;
    iLM_WriteEnable = '0; iLM_ReadEnable = '0; iLM_WriteAddress = '0; iLM_WriteData = '0;
    iLM_ReadAddress = '0; iIM_ReadEnable = '0; iIM_ReadAddress = '0;
    iLoad_Valid = 1'b0; iLoad_Data = '0;

    // Reset state
    #2;
    check("rst_ready", 64'(oLoad_Ready), 64'd0);
    check("rst_busy",  64'(oLoad_Busy),  64'd0);
    check("rst_done",  64'(oLoad_Done),  64'd0);
    check("rst_error", 64'(oLoad_Error), 64'd0);
    check("rst_im_q",  64'(oIM_ReadData == '0), 64'd1);
    check("rst_lm_q",  64'(oLM_ReadData), 64'd0);
    @(negedge iClk); @(negedge iClk);
    iReset = 1'b0;
    #1 check("ready_after_rst", 64'(oLoad_Ready), 64'd1);
    @(negedge iClk);

    // Four-beat burst into ID0 at 0x10
    doneBefore = doneCount;
    beats = {};
    for (int k = 0; k < 4; k++) beats.push_back(rand40());
    sendBeat(hdr(0, 'h10, 4));
    check("id0_busy_after_hdr", 64'(oLoad_Busy), 64'd1);
    foreach (beats[k]) sendBeat(beats[k]);
    modelBurst(0, 'h10, beats);
    check("id0_done_pulse", 64'(oLoad_Done), 64'd1);
    check("id0_busy_low",   64'(oLoad_Busy), 64'd0);
    @(negedge iClk);
    check("id0_done_clear", 64'(oLoad_Done), 64'd0);
    @(negedge iClk);
    check("id0_done_once", 64'(doneCount - doneBefore), 64'd1);
    for (int a = 'h10; a < 'h14; a++) begin
      readIm(0, a, q);
      check($sformatf("id0_rd_%0h", a), q, 64'(idModel[0][a]));
    end

    // IMM burst wrapping from 0xFF to 0x00
    beats = {};
    beats.push_back(40'h1_FFFF_FFFF);
    beats.push_back(rand40());
    sendBurst(NI, 'hFF, beats);
    modelBurst(NI, 'hFF, beats);
    readIm(NI, 'hFF, q);
    check("imm_rd_ff", q, 64'(immModel['hFF]));
    check("imm_rd_ff_const", q, 64'h1_FFFF_FFFF);
    readIm(NI, 'h00, q);
    check("imm_rd_00_wrap", q, 64'(immModel[0]));

    // Invalid target: beats drained, error sticky, no memory changes
    sendBeat(hdr('h7F, 'h10, 3));
    check("bad_busy",  64'(oLoad_Busy),  64'd1);
    check("bad_error", 64'(oLoad_Error), 64'd1);
    for (int k = 0; k < 3; k++) sendBeat(rand40());
    check("bad_busy_low", 64'(oLoad_Busy), 64'd0);
    for (int a = 'h10; a < 'h14; a++) begin
      readIm(0, a, q);
      check($sformatf("bad_id0_keep_%0h", a), q, 64'(idModel[0][a]));
    end
    readIm(NI, 'hFF, q);
    check("bad_imm_keep", q, 64'(immModel['hFF]));

    // LM burst of 8 paused by iRun after beat 3
    base = 'h80;
    beats = {};
    for (int k = 0; k < 8; k++) beats.push_back(rand40());
    sendBeat(hdr(NI + 1, base, 8));
    for (int k = 0; k < 3; k++) sendBeat(beats[k]);
    iRun = 1'b1;
    iLoad_Valid = 1'b1;
    iLoad_Data  = beats[3];
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("pause_ready_%0d", c), 64'(oLoad_Ready), 64'd0);
      check($sformatf("pause_busy_%0d", c),  64'(oLoad_Busy),  64'd1);
      @(negedge iClk);
    end
    iRun = 1'b0;
    for (int k = 3; k < 8; k++) sendBeat(beats[k]);
    modelBurst(NI + 1, base, beats);
    check("pause_busy_low", 64'(oLoad_Busy), 64'd0);
    for (int k = 0; k < 8; k++) begin
      readLm(base + k, q);
      check($sformatf("pause_lm_%0d", k), q, 64'(lmModel[base + k]));
    end

    // Loader/array write collision on LM0
    w6 = $urandom; x5 = $urandom; x6 = $urandom; y6 = $urandom;
    l5 = rand40(); l20 = rand40();
    arrayWrite(4'hF, 6, w6);
    sendBeat(hdr(NI + 1, 5, 1));
    beatWithArrayWrite(l5, 5, x5);
    lmModel[5] = l5[31:0];
    sendBeat(hdr(NI + 1, 20, 1));
    beatWithArrayWrite(l20, 6, x6);
    lmModel[20] = l20[31:0];
    arrayWrite(4'b0101, 6, y6);
    readLm(5, q);
    check("mux_loader_wins", q, 64'(lmModel[5]));
    readLm(20, q);
    check("mux_loader_20", q, 64'(lmModel[20]));
    readLm(6, q);
    check("mux_array_dropped_then_be", q, 64'(lmModel[6]));

    // Read-during-write returns old data; rden=0 holds q
    v1 = $urandom; v2 = $urandom;
    arrayWrite(4'hF, 'h30, v1);
    iLM_ReadEnable = 1'b1; iLM_ReadAddress = 8'h30;
    arrayWrite(4'hF, 'h30, v2);
    iLM_ReadEnable = 1'b0;
    check("rdw_old_data", 64'(oLM_ReadData), 64'(v1));
    readLm('h30, q);
    check("rdw_new_data", q, 64'(v2));
    qHold = q;
    iLM_ReadAddress = 8'h80;
    @(negedge iClk); @(negedge iClk);
    check("rden_hold", 64'(oLM_ReadData), qHold);
    check("error_sticky", 64'(oLoad_Error), 64'd1);

    // Reset after 2 of 6 beats
    base = 'h50;
    beats = {};
    for (int k = 0; k < 2; k++) beats.push_back(rand40());
    sendBeat(hdr(0, base, 6));
    foreach (beats[k]) sendBeat(beats[k]);
    modelBurst(0, base, beats);
    check("mid_busy", 64'(oLoad_Busy), 64'd1);
    iReset = 1'b1;
    #1;
    check("mid_rst_busy",  64'(oLoad_Busy),  64'd0);
    check("mid_rst_ready", 64'(oLoad_Ready), 64'd0);
    check("mid_rst_error", 64'(oLoad_Error), 64'd0);
    check("mid_rst_lm_q",  64'(oLM_ReadData), 64'd0);
    @(negedge iClk);
    iReset = 1'b0;
    beats = {};
    for (int k = 0; k < 2; k++) beats.push_back(rand40());
    sendBurst(1, 'h40, beats);
    modelBurst(1, 'h40, beats);
    check("post_rst_busy", 64'(oLoad_Busy), 64'd0);
    for (int k = 0; k < 2; k++) begin
      readIm(1, 'h40 + k, q);
      check($sformatf("post_rst_id1_%0d", k), q, 64'(idModel[1]['h40 + k]));
      readIm(0, base + k, q);
      check($sformatf("post_rst_id0_kept_%0d", k), q, 64'(idModel[0][base + k]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
